// File: rtl/lsu_mem_stage_if.sv
// Request, data-memory and write-back signal bundle for the MEM-stage load/store unit.
interface lsu_mem_stage_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_is_load;
    logic        i_req_is_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [4:0]  i_rd;

    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic        o_mem_write;
    logic        o_store_byte;
    logic        o_store_half;
    logic [31:0] i_mem_data;

    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic [4:0]  o_resp_rd;
    logic        o_resp_we;
    logic        o_fault;
    logic [1:0]  o_fault_cause;
    logic [31:0] o_fault_addr;
    logic        o_busy;

    // Requester / memory / write-back side
    modport master (
        output i_req_valid, i_req_is_load, i_req_is_store, i_funct3, i_addr, i_wdata, i_rd,
        output i_mem_data,
        input  o_req_ready, o_mem_addr, o_mem_data, o_mem_write, o_store_byte, o_store_half,
        input  o_resp_valid, o_resp_rdata, o_resp_rd, o_resp_we,
        input  o_fault, o_fault_cause, o_fault_addr, o_busy
    );

    // Load/store unit side
    modport slave (
        input  i_req_valid, i_req_is_load, i_req_is_store, i_funct3, i_addr, i_wdata, i_rd,
        input  i_mem_data,
        output o_req_ready, o_mem_addr, o_mem_data, o_mem_write, o_store_byte, o_store_half,
        output o_resp_valid, o_resp_rdata, o_resp_rd, o_resp_we,
        output o_fault, o_fault_cause, o_fault_addr, o_busy
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: fault checks a request, drives the data memory for one
// cycle and returns an extended load result as a single-cycle response pulse.
module lsu_mem_stage #(
    parameter int unsigned MEM_BYTES = 1048576
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clk_enable,
    input  logic           i_flush,
    lsu_mem_stage_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_MISALGN = 2'd1;
    localparam logic [1:0] CAUSE_RANGE   = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        is_load_q;
    logic        is_store_q;
    logic [4:0]  rd_q;
    logic        fault_q;
    logic [1:0]  cause_q;
    logic [31:0] rdata_q;

    logic        accept_c;
    logic        illegal_c;
    logic        misalign_c;
    logic        range_c;
    logic [1:0]  cause_c;
    logic [32:0] size_m1_c;
    logic [32:0] last_byte_c;
    logic [31:0] ext_c;
    logic        resp_valid_c;

    assign accept_c = (state_q == ST_IDLE) && bus.i_req_valid && i_clk_enable && !i_flush;

    // Fault classification of the incoming request, highest priority first
    always_comb begin
        illegal_c  = 1'b0;
        misalign_c = 1'b0;
        size_m1_c  = 33'd0;
        cause_c    = CAUSE_NONE;
        if (bus.i_req_is_load == bus.i_req_is_store)
            illegal_c = 1'b1;
        else if (bus.i_req_is_load)
            illegal_c = (bus.i_funct3 == 3'd3) || (bus.i_funct3 == 3'd6) || (bus.i_funct3 == 3'd7);
        else
            illegal_c = (bus.i_funct3 >= 3'd3);

        case (bus.i_funct3[1:0])
            2'b00:   size_m1_c = 33'd0;
            2'b01:   begin
                size_m1_c  = 33'd1;
                misalign_c = bus.i_addr[0];
            end
            default: begin
                size_m1_c  = 33'd3;
                misalign_c = (bus.i_addr[1:0] != 2'b00);
            end
        endcase

        if (illegal_c)       cause_c = CAUSE_ILLEGAL;
        else if (misalign_c) cause_c = CAUSE_MISALGN;
        else if (range_c)    cause_c = CAUSE_RANGE;
    end

    // 33-bit sum keeps accesses near the top of the address space from wrapping
    assign last_byte_c = {1'b0, bus.i_addr} + size_m1_c;
    assign range_c     = (last_byte_c >= 33'(MEM_BYTES));

    always_comb begin
        ext_c = bus.i_mem_data;
        case (funct3_q)
            3'b000:  ext_c = {{24{bus.i_mem_data[7]}},  bus.i_mem_data[7:0]};
            3'b001:  ext_c = {{16{bus.i_mem_data[15]}}, bus.i_mem_data[15:0]};
            3'b100:  ext_c = {24'd0, bus.i_mem_data[7:0]};
            3'b101:  ext_c = {16'd0, bus.i_mem_data[15:0]};
            default: ext_c = bus.i_mem_data;
        endcase
    end

    // Next-state logic; the register only advances on enabled cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept_c) state_d = (cause_c != CAUSE_NONE) ? ST_RESP : ST_ACCESS;
            ST_ACCESS: state_d = i_flush ? ST_IDLE : ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= ST_IDLE;
        else if (i_clk_enable)
            state_q <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            funct3_q   <= 3'd0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            rd_q       <= 5'd0;
            fault_q    <= 1'b0;
            cause_q    <= CAUSE_NONE;
            rdata_q    <= 32'd0;
        end else if (i_clk_enable) begin
            if (accept_c) begin
                addr_q     <= bus.i_addr;
                wdata_q    <= bus.i_wdata;
                funct3_q   <= bus.i_funct3;
                is_load_q  <= bus.i_req_is_load;
                is_store_q <= bus.i_req_is_store;
                rd_q       <= bus.i_rd;
                fault_q    <= (cause_c != CAUSE_NONE);
                cause_q    <= cause_c;
                rdata_q    <= 32'd0;
            end else if ((state_q == ST_ACCESS) && is_load_q && !i_flush) begin
                rdata_q    <= ext_c;
            end
        end
    end

    assign resp_valid_c = (state_q == ST_RESP) && !i_flush;

    assign bus.o_req_ready   = (state_q == ST_IDLE) && !i_rst;
    assign bus.o_busy        = (state_q != ST_IDLE);
    assign bus.o_mem_addr    = addr_q;
    assign bus.o_mem_data    = wdata_q;
    assign bus.o_mem_write   = (state_q == ST_ACCESS) && is_store_q && !i_flush;
    assign bus.o_store_byte  = (state_q == ST_ACCESS) && (funct3_q == 3'b000);
    assign bus.o_store_half  = (state_q == ST_ACCESS) && (funct3_q == 3'b001);
    assign bus.o_resp_valid  = resp_valid_c;
    assign bus.o_resp_rdata  = rdata_q;
    assign bus.o_resp_rd     = rd_q;
    assign bus.o_resp_we     = resp_valid_c && is_load_q && !fault_q && (rd_q != 5'd0);
    assign bus.o_fault       = resp_valid_c && fault_q;
    assign bus.o_fault_cause = resp_valid_c ? cause_q : CAUSE_NONE;
    assign bus.o_fault_addr  = (resp_valid_c && fault_q) ? addr_q : 32'd0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage: loads, stores, faults, stalls, flush, reset.
module tb_lsu_mem_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_enable = 1'b1;
    logic flush = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    lsu_mem_stage_if bus ();

    lsu_mem_stage #(.MEM_BYTES(1048576)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clk_enable (clk_enable),
        .i_flush      (flush),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in the cycle after the accepting edge
    task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        bus.i_req_is_load  = ld;
        bus.i_req_is_store = st;
        bus.i_funct3       = f3;
        bus.i_addr         = addr;
        bus.i_wdata        = wdata;
        bus.i_rd           = rd;
        bus.i_req_valid    = 1'b1;
        tick();
        bus.i_req_valid    = 1'b0;
    endtask

    task automatic run_ok(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] exp_rdata, input logic exp_we);
        drive_req(ld, st, f3, addr, wdata, rd);
        check({tag, "_busy"},   32'(bus.o_busy), 32'd1);
        check({tag, "_rv_n1"},  32'(bus.o_resp_valid), 32'd0);
        check({tag, "_mw_n1"},  32'(bus.o_mem_write), 32'(st));
        check({tag, "_maddr"},  bus.o_mem_addr, addr);
        if (st) begin
            check({tag, "_mdata"}, bus.o_mem_data, wdata);
            check({tag, "_sbyte"}, 32'(bus.o_store_byte), 32'(f3 == 3'b000));
            check({tag, "_shalf"}, 32'(bus.o_store_half), 32'(f3 == 3'b001));
        end
        tick();
        check({tag, "_rv_n2"},  32'(bus.o_resp_valid), 32'd1);
        check({tag, "_mw_n2"},  32'(bus.o_mem_write), 32'd0);
        check({tag, "_rdata"},  bus.o_resp_rdata, exp_rdata);
        check({tag, "_we"},     32'(bus.o_resp_we), 32'(exp_we));
        check({tag, "_fault"},  32'(bus.o_fault), 32'd0);
        if (ld) check({tag, "_rd"}, 32'(bus.o_resp_rd), 32'(rd));
        tick();
        check({tag, "_rv_n3"},  32'(bus.o_resp_valid), 32'd0);
        check({tag, "_ready"},  32'(bus.o_req_ready), 32'd1);
    endtask

    task automatic run_fault(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [1:0] cause);
        drive_req(ld, st, f3, addr, 32'h1234_5678, 5'd7);
        check({tag, "_rv_n1"},  32'(bus.o_resp_valid), 32'd1);
        check({tag, "_mw"},     32'(bus.o_mem_write), 32'd0);
        check({tag, "_fault"},  32'(bus.o_fault), 32'd1);
        check({tag, "_cause"},  32'(bus.o_fault_cause), 32'(cause));
        check({tag, "_faddr"},  bus.o_fault_addr, addr);
        check({tag, "_we"},     32'(bus.o_resp_we), 32'd0);
        check({tag, "_rdata"},  bus.o_resp_rdata, 32'd0);
        tick();
        check({tag, "_idle"},   32'(bus.o_req_ready), 32'd1);
        check({tag, "_rv_n2"},  32'(bus.o_resp_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.i_req_valid    = 1'b0;
        bus.i_req_is_load  = 1'b0;
        bus.i_req_is_store = 1'b0;
        bus.i_funct3       = 3'd0;
        bus.i_addr         = 32'd0;
        bus.i_wdata        = 32'd0;
        bus.i_rd           = 5'd0;
        bus.i_mem_data     = 32'h0000_80F0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_ready",  32'(bus.o_req_ready), 32'd1);
        check("rst_busy",   32'(bus.o_busy), 32'd0);
        check("rst_rv",     32'(bus.o_resp_valid), 32'd0);
        check("rst_mw",     32'(bus.o_mem_write), 32'd0);
        check("rst_maddr",  bus.o_mem_addr, 32'd0);
        tick();

        // Store, then the four sub-word loads against 0x000080F0
        run_ok("sw",  1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b0);
        run_ok("sb",  1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00AA, 5'd0, 32'd0, 1'b0);
        run_ok("lb",  1'b1, 1'b0, 3'b000, 32'h10, 32'd0, 5'd5, 32'hFFFF_FFF0, 1'b1);
        run_ok("lbu", 1'b1, 1'b0, 3'b100, 32'h10, 32'd0, 5'd5, 32'h0000_00F0, 1'b1);
        run_ok("lh",  1'b1, 1'b0, 3'b001, 32'h10, 32'd0, 5'd5, 32'hFFFF_80F0, 1'b1);
        run_ok("lhu", 1'b1, 1'b0, 3'b101, 32'h10, 32'd0, 5'd5, 32'h0000_80F0, 1'b1);
        run_ok("lw_top", 1'b1, 1'b0, 3'b010, 32'hFFFFC, 32'd0, 5'd9, 32'h0000_80F0, 1'b1);

        run_fault("lw_mis",   1'b1, 1'b0, 3'b010, 32'h102,    2'd1);
        run_fault("sh_mis",   1'b0, 1'b1, 3'b001, 32'hFFFFF,  2'd1);
        run_fault("sw_mis",   1'b0, 1'b1, 3'b010, 32'hFFFFE,  2'd1);
        run_fault("lw_range", 1'b1, 1'b0, 3'b010, 32'h100000, 2'd2);
        run_fault("lb_range", 1'b1, 1'b0, 3'b000, 32'hFFFF_FFFF, 2'd2);
        run_fault("ld_ill",   1'b1, 1'b0, 3'b011, 32'h0,      2'd3);
        run_fault("st_ill",   1'b0, 1'b1, 3'b100, 32'h3,      2'd3);
        run_fault("both_ill", 1'b1, 1'b1, 3'b010, 32'h40,     2'd3);

        // Stall in ACCESS for a load to x0
        drive_req(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 5'd0);
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_busy", 32'(bus.o_busy), 32'd1);
            check("stl_rv",   32'(bus.o_resp_valid), 32'd0);
        end
        clk_enable = 1'b1;
        tick();
        check("stl_rv_late", 32'(bus.o_resp_valid), 32'd1);
        check("stl_we_x0",   32'(bus.o_resp_we), 32'd0);
        check("stl_rdata",   bus.o_resp_rdata, 32'h0000_80F0);
        tick();

        // Stalled store keeps the write enable up
        drive_req(1'b0, 1'b1, 3'b010, 32'h200, 32'h0BAD_F00D, 5'd0);
        clk_enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("sts_mw", 32'(bus.o_mem_write), 32'd1);
        end
        clk_enable = 1'b1;
        tick();
        check("sts_rv", 32'(bus.o_resp_valid), 32'd1);
        check("sts_mw_off", 32'(bus.o_mem_write), 32'd0);
        tick();

        // Flush an SB in ACCESS
        drive_req(1'b0, 1'b1, 3'b000, 32'h40, 32'h55, 5'd0);
        check("fl_mw_pre", 32'(bus.o_mem_write), 32'd1);
        flush = 1'b1;
        #1;
        check("fl_mw", 32'(bus.o_mem_write), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_busy", 32'(bus.o_busy), 32'd0);
        check("fl_rv",   32'(bus.o_resp_valid), 32'd0);
        tick();
        check("fl_rv2",  32'(bus.o_resp_valid), 32'd0);

        // Flush a load in RESP
        drive_req(1'b1, 1'b0, 3'b100, 32'h10, 32'd0, 5'd3);
        tick();
        flush = 1'b1;
        #1;
        check("flr_rv", 32'(bus.o_resp_valid), 32'd0);
        check("flr_we", 32'(bus.o_resp_we), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flr_idle", 32'(bus.o_busy), 32'd0);

        // Asynchronous reset in ACCESS
        drive_req(1'b0, 1'b1, 3'b010, 32'h80, 32'hCAFE_BABE, 5'd0);
        check("ar_mw_pre", 32'(bus.o_mem_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_busy",  32'(bus.o_busy), 32'd0);
        check("ar_mw",    32'(bus.o_mem_write), 32'd0);
        check("ar_ready", 32'(bus.o_req_ready), 32'd0);
        check("ar_maddr", bus.o_mem_addr, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("ar_rel_ready", 32'(bus.o_req_ready), 32'd1);
        tick();
        run_ok("post_rst", 1'b1, 1'b0, 3'b100, 32'h10, 32'd0, 5'd4, 32'h0000_00F0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the MEM pipeline stage. It sits directly upstream of the byte-addressed data memory. It accepts one load or store request from the EX/MEM register and checks it for width, alignment and range faults. It then drives the memory's address, write-data, write-enable and store-width strobes, and sign/zero-extends read data into a write-back response. It is a three-state FSM with a valid/ready request handshake and a single-cycle response pulse.

## Interface
- MEM_BYTES, 1048576: data memory size in bytes; any access touching a byte at or above this is out of range.
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_clk_enable  in  1  global stall-release; when low, all state and registers hold.
- i_flush  in  1  squash the in-flight request.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  `state==IDLE && !i_rst`.
- i_req_is_load / i_req_is_store  in  1 each  request type.
- i_funct3  in  3  RV32I load/store width field.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data.
- i_rd  in  5  load destination register.
- o_mem_addr  out  32  latched address to memory.
- o_mem_data  out  32  latched store data, unshifted.
- o_mem_write  out  1  memory write enable.
- o_store_byte / o_store_half  out  1 each  store width strobes.
- i_mem_data  in  32  combinational read data; bits [7:0] are the byte at o_mem_addr, little-endian.
- o_resp_valid  out  1  one-cycle completion pulse.
- o_resp_rdata  out  32  extended load data.
- o_resp_rd  out  5  destination register.
- o_resp_we  out  1  register-file write enable.
- o_fault  out  1  request faulted.
- o_fault_cause  out  2  fault code: 0 none, 1 misaligned, 2 out of range, 3 illegal.
- o_fault_addr  out  32  faulting address.
- o_busy  out  1  `state!=IDLE`; stalls upstream.

## Operation
- States are IDLE, ACCESS and RESP. Reset value is IDLE, and all latched registers and response outputs reset to 0.
- Nothing advances while i_clk_enable=0.
- In IDLE, the request is accepted when `i_req_valid && i_clk_enable && !i_flush`. Accepting latches the address, wdata, funct3, type and rd, and evaluates the fault.
  - No fault: go to ACCESS.
  - Fault: go to RESP with the fault registered.
- Fault priority is illegal, then misaligned, then range.
  - Illegal (cause 3): is_load and is_store are both 1 or both 0; a load uses funct3 3, 6 or 7; or a store uses funct3 3–7.
  - Misaligned (cause 1): a halfword access with addr[0]=1, or a word access with addr[1:0]≠0.
  - Out of range (cause 2): `addr + size − 1 ≥ MEM_BYTES`. The compare is 33 bits wide, so no wrap-around.
- Memory outputs:
  - o_mem_addr and o_mem_data come from the latched registers in all states.
  - `o_mem_write = (state==ACCESS) && store && !i_flush`.
  - o_store_byte is 1 for funct3 000; o_store_half is 1 for funct3 001.
  - All three (o_mem_write, o_store_byte, o_store_half) are 0 outside ACCESS.
- ACCESS lasts one enabled cycle, then goes to RESP.
  - A load captures the extended i_mem_data into o_resp_rdata at the exit edge.
  - Load extension by funct3:
    - 000 → sign-extend [7:0].
    - 001 → sign-extend [15:0].
    - 010 → pass [31:0] through.
    - 100 → zero-extend [7:0].
    - 101 → zero-extend [15:0].
- RESP lasts one enabled cycle, then goes to IDLE. During RESP:
  - `o_resp_valid = !i_flush`.
  - `o_resp_we = o_resp_valid && load && !fault && rd≠0`.
  - o_resp_rdata is 0 for stores and for faults.
  - o_fault and o_fault_addr are valid only while o_resp_valid=1.
- Flush in ACCESS or RESP returns to IDLE on the next enabled edge. The flushed request produces no write and no response.
- Asserting reset mid-operation forces IDLE immediately. A store in ACCESS is dropped because o_mem_write is gated by state.

## Timing
- Request accepted at edge N, memory access in cycle N+1, o_resp_valid high in cycle N+2. With no stalls, latency is 2 cycles.
- A faulting request goes from accept to RESP directly, so o_resp_valid is high in cycle N+1.
- Throughput is one request per 3 cycles, or one per 2 cycles for faults. o_req_ready is low while busy.
- i_clk_enable low stretches the current state indefinitely. Outputs hold, and o_mem_write remains asserted if the state is ACCESS with a store; the memory ignores it while disabled.
- A back-to-back request is accepted in the cycle the FSM returns to IDLE, not in the RESP cycle.

## Test plan
- After reset: o_req_ready=1, o_busy=0, o_resp_valid=0, o_mem_write=0. Issue SW addr 0x100, wdata 0xDEADBEEF → o_mem_write=1 for exactly one cycle with o_store_byte=o_store_half=0 → RESP has o_resp_we=0 and o_fault=0.
- Load with i_mem_data=0x000080F0, rd=5:
  - LB at 0x10 → rdata 0xFFFFFFF0.
  - LBU → 0x000000F0.
  - LH → 0xFFFF80F0.
  - LHU → 0x000080F0.
  - Each has o_resp_we=1, o_resp_rd=5, and o_resp_valid high 2 cycles after accept.
- Faults, each with no o_mem_write and o_resp_valid in cycle N+1:
  - LW at 0x102 → cause 1, o_fault_addr=0x102.
  - SH at 0xFFFFF → cause 1.
  - SW at 0xFFFFE → cause 1; misaligned wins over range.
  - LW at 0xFFFFC → no fault.
  - LW at 0x100000 → cause 2.
  - Load with funct3=011 → cause 3.
- Hold i_clk_enable low for 3 cycles while in ACCESS: the state is held, and the response arrives exactly 3 cycles later than nominal. LW to rd=0 → o_resp_valid=1 with o_resp_we=0.
- Flush:
  - Assert i_flush in ACCESS for an SB → o_mem_write=0 and no response.
  - Assert i_rst asynchronously mid-ACCESS → o_busy=0 immediately, no write.
  - A new request after release completes normally.
